// File: rtl/pattern_detect_scheduler.sv
// rtl/pattern_detect_scheduler.sv - round-robin sharing of one serial pattern detector between two word requesters
// Optional abort input / aborted output: define PDS_ABORT_EN.
module pattern_detect_scheduler #(
    parameter int W         = 8,
    parameter int FLUSH_LEN = 3,
    parameter int Z_LAT     = 2,
    parameter int CW        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [W-1:0]  data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [W-1:0]  data1,
    output logic          gnt1,
    output logic          det_x,
    input  logic          det_z,
`ifdef PDS_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [CW-1:0] hit_cnt
);

    localparam int CMAX  = (W > FLUSH_LEN) ? ((W > Z_LAT) ? W : Z_LAT)
                                           : ((FLUSH_LEN > Z_LAT) ? FLUSH_LEN : Z_LAT);
    localparam int CNT_W = $clog2(CMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_SHIFT, S_DRAIN, S_REPORT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_shreg;
    logic             r_id;
    logic             r_last_id;
    logic [CW-1:0]    r_hits;
    logic             r_count_en;
    logic             r_gnt0, r_gnt1, r_det_x, r_busy, r_done, r_done_id;
    logic [CW-1:0]    r_hit_cnt;
`ifdef PDS_ABORT_EN
    logic             r_abort;
    logic             r_aborted;
    assign aborted = r_aborted;
`endif

    logic             w_pick1;
    logic [CW-1:0]    w_hits_next;

    assign w_pick1 = req1 && (!req0 || !r_last_id);

    // r_count_en marks cycles whose det_x came from SHIFT/DRAIN; det_z is counted in those cycles
    always_comb begin
        w_hits_next = r_hits;
        if (r_count_en && det_z && (r_hits != {CW{1'b1}}))
            w_hits_next = r_hits + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_id       <= 1'b0;
            r_last_id  <= 1'b1;
            r_hits     <= '0;
            r_count_en <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_det_x    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= 1'b0;
            r_hit_cnt  <= '0;
`ifdef PDS_ABORT_EN
            r_abort    <= 1'b0;
            r_aborted  <= 1'b0;
`endif
        end else begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done     <= 1'b0;
            r_det_x    <= 1'b0;
            r_count_en <= 1'b0;
            r_hits     <= w_hits_next;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (req0 || req1) begin
                        r_gnt0    <= !w_pick1;
                        r_gnt1    <= w_pick1;
                        r_shreg   <= w_pick1 ? data1 : data0;
                        r_id      <= w_pick1;
                        r_last_id <= w_pick1;
                        r_hits    <= '0;
                        r_cnt     <= '0;
`ifdef PDS_ABORT_EN
                        r_abort   <= 1'b0;
`endif
                        r_state   <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_busy <= 1'b1;
                    if (r_cnt == CNT_W'(FLUSH_LEN - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    r_det_x    <= r_shreg[W-1];
                    r_shreg    <= r_shreg << 1;
                    r_count_en <= 1'b1;
                    if (r_cnt == CNT_W'(W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_count_en <= 1'b1;
                    if (r_cnt == CNT_W'(Z_LAT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_REPORT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_REPORT: begin
                    r_done    <= 1'b1;
                    r_done_id <= r_id;
`ifdef PDS_ABORT_EN
                    r_hit_cnt <= r_abort ? '0 : w_hits_next;
                    r_aborted <= r_abort;
`else
                    r_hit_cnt <= w_hits_next;
`endif
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef PDS_ABORT_EN
            if (abort && (r_state == S_FLUSH || r_state == S_SHIFT || r_state == S_DRAIN)) begin
                r_det_x    <= 1'b0;
                r_count_en <= 1'b0;
                r_abort    <= 1'b1;
                r_cnt      <= '0;
                r_state    <= S_REPORT;
            end
`endif
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign det_x   = r_det_x;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_pattern_detect_scheduler.sv
// tb/tb_pattern_detect_scheduler.sv - directed/random bench for pattern_detect_scheduler (CW=4 and CW=3 instances)
module tb_pattern_detect_scheduler;

    localparam int W   = 8;
    localparam int FL  = 3;
    localparam int ZL  = 2;
    localparam int LAT = FL + W + ZL + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, det_z = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;

    logic       gnt0, gnt1, det_x, busy, done, done_id;
    logic [3:0] hit_cnt;
    logic       s_gnt0, s_gnt1, s_det_x, s_busy, s_done, s_done_id;
    logic [2:0] s_hit_cnt;

    int n_chk = 0;
    int n_pass = 0;
    bit last_id = 1'b1;

    always #5 clk = ~clk;

    pattern_detect_scheduler #(.W(W), .FLUSH_LEN(FL), .Z_LAT(ZL), .CW(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .det_x(det_x), .det_z(det_z),
        .busy(busy), .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
    );

    pattern_detect_scheduler #(.W(W), .FLUSH_LEN(FL), .Z_LAT(ZL), .CW(3)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .gnt0(s_gnt0),
        .req1(req1), .data1(data1), .gnt1(s_gnt1),
        .det_x(s_det_x), .det_z(det_z),
        .busy(s_busy), .done(s_done), .done_id(s_done_id), .hit_cnt(s_hit_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expects one grant then a full job; zv[k] is det_z driven in cycle k after the grant cycle (k=0).
    task automatic do_job(input logic [14:0] zv, input int max_wait, output int waited);
        bit         exp_id;
        logic [7:0] word;
        int         hits;
        logic       exp_x;
        exp_id = (req0 && req1) ? !last_id : !req0;
        waited = 0;
        @(negedge clk);
        while (!(gnt0 || gnt1) && waited < max_wait) begin
            waited++;
            @(negedge clk);
        end
        chk("gnt_seen", gnt0 | gnt1, 1);
        chk("gnt0", gnt0, !exp_id);
        chk("gnt1", gnt1, exp_id);
        chk("busy_at_gnt", busy, 0);
        last_id = exp_id;
        word = exp_id ? data1 : data0;
        hits = 0;
        det_z = zv[0];
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            det_z = zv[k];
            if (k >= FL + 1 && k <= FL + W + ZL) hits += int'(zv[k]);
            if (k >= FL + 1 && k <= FL + W) exp_x = word[W-1-(k-FL-1)];
            else exp_x = 1'b0;
            if (k < LAT) chk($sformatf("det_x_k%0d", k), det_x, exp_x);
            chk($sformatf("busy_k%0d", k), busy, 1);
            chk($sformatf("no_gnt_k%0d", k), gnt0 | gnt1, 0);
            chk($sformatf("done_k%0d", k), done, k == LAT);
        end
        chk("done_id", done_id, exp_id);
        chk("hit_cnt", hit_cnt, (hits > 15) ? 15 : hits);
        chk("sat_done", s_done, 1);
        chk("sat_hit_cnt", s_hit_cnt, (hits > 7) ? 7 : hits);
    endtask

    initial begin
        int w;
        bit r0;
        // reset held with a pending request
        #1 rst_n = 1'b0;
        req0 = 1'b1;
        data0 = 8'b10110100;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt0", gnt0, 0);
            chk("rst_det_x", det_x, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end
        rst_n = 1'b1;
        last_id = 1'b1;
        // single job with det_z high in three counted cycles
        do_job(15'h1220, 20, w);
        chk("first_gnt_latency", w, 0);
        req0 = 1'b0;
        @(negedge clk);
        chk("busy_drop", busy, 0);
        chk("idle_no_gnt", gnt0 | gnt1, 0);

        // simultaneous requests after reset, fairness over four jobs, saturation on job three
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_id = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        data0 = 8'($urandom());
        data1 = 8'($urandom());
        do_job(15'($urandom()), 20, w);
        chk("sim_gap0", w, 0);
        do_job(15'($urandom()), 20, w);
        chk("sim_gap1", w, 0);
        do_job(15'h7fff, 20, w);
        chk("sim_gap2", w, 0);
        do_job(15'($urandom()), 20, w);
        chk("sim_gap3", w, 0);

        // random request mixes and words
        for (int j = 0; j < 6; j++) begin
            r0 = 1'($urandom());
            req0 = r0;
            req1 = !r0 | 1'($urandom());
            data0 = 8'($urandom());
            data1 = 8'($urandom());
            do_job(15'($urandom()), 20, w);
            chk("rand_gap", w, 0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);

        // reset in the fifth SHIFT cycle
        req1 = 1'b1;
        data1 = 8'hFF;
        w = 0;
        @(negedge clk);
        while (!gnt1 && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("mid_gnt1", gnt1, 1);
        repeat (FL + 5) @(negedge clk);
        chk("mid_det_x_before", det_x, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_det_x_async", det_x, 0);
        chk("mid_busy_async", busy, 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_no_done", done, 0);
        end
        rst_n = 1'b1;
        last_id = 1'b1;
        data1 = 8'($urandom());
        do_job(15'($urandom()), 20, w);
        chk("post_rst_gap", w, 0);
        req1 = 1'b0;
        @(negedge clk);
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
